unified_mem_arbiter: RTL and testbench
======================================

// Module: unified_mem_arbiter
// PURPOSE
//  Shares one byte-addressed unified memory between two requesters: the IF stage
//  (instruction fetch, read-only) and the MEM stage (load/store).
//  Memory port: 4-bit byte write-enable, 16-bit byte address, 32-bit write/read data.
//  Memory reads are combinational; writes commit on posedge clk.
//  Sits between the pipeline's hazard/stall logic and the memory. Serialises
//  accesses, registers responses, and guarantees IF forward progress.
// PARAMETERS
//  ADDR_W        16  byte address width (memory depth 2**ADDR_W bytes)
//  DATA_W        32  data width; byte mask width = DATA_W/8
//  STARVE_LIMIT  4   consecutive IF losses before IF is forced to win (1..15)
//  CNT_W         16  perf counter width (used only with ARB_PERF_CNT_EN)
// PORTS
//  clk           in   1       rising-edge clock
//  rst           in   1       synchronous, active-high reset
//  i_req_valid   in   1       IF fetch request
//  i_req_ready   out  1       IF request accepted this cycle
//  i_addr        in   ADDR_W  IF byte address
//  i_resp_valid  out  1       one-cycle pulse; i_rdata valid
//  i_rdata       out  DATA_W  fetched word
//  d_req_valid   in   1       MEM-stage request
//  d_req_ready   out  1       MEM request accepted this cycle
//  d_addr        in   ADDR_W  data byte address
//  d_we          in   1       1=store, 0=load
//  d_wmask       in   4       byte enables for store
//  d_wdata       in   DATA_W  store data
//  d_resp_valid  out  1       one-cycle pulse; load data valid / store done
//  d_rdata       out  DATA_W  load word (0 for stores)
//  mem_w_en      out  4       to memory byte write-enable
//  mem_address   out  ADDR_W  to memory address
//  mem_wdata     out  DATA_W  to memory write data
//  mem_rdata     in   DATA_W  from memory (combinational read, valid when w_en==0)
// BEHAVIOUR
//  FSM: IDLE -> ACCESS -> RESP -> IDLE. Registered request: owner, addr, we, mask, wdata.
//  IDLE: ready asserted combinationally to the winner only. On valid&&ready, latch the
//   request and go to ACCESS. If no request, stay in IDLE.
//  ACCESS: mem_address = latched addr.
//   - Store: mem_w_en = latched mask, mem_wdata = latched wdata.
//   - Load/fetch: mem_w_en = 0; mem_rdata captured into the owner's rdata register.
//   Go to RESP.
//  RESP: owner's resp_valid = 1 for exactly one cycle. Go to IDLE.
//   Latency: accept -> resp_valid = 2 cycles. Throughput: 1 access per 3 cycles.
//  Outside ACCESS: mem_w_en = 0, mem_address = 0, mem_wdata = 0.
//   No spurious writes ever.
//  Arbitration (IDLE only):
//   - Only one valid: it wins.
//   - Both valid: d wins, unless starve_cnt == STARVE_LIMIT, then i wins.
//   - starve_cnt: +1 when i is valid but loses (saturates at STARVE_LIMIT);
//     cleared when i is granted.
//  Store with d_wmask == 0: no byte written; still 2-cycle ack; d_rdata = 0.
//  Store response: d_rdata = 0. i_rdata/d_rdata hold until the next own response.
//  Address is passed through unmodified. Misaligned/wrapping addresses are the
//   memory's concern (wraps mod 2**ADDR_W).
//  Requester may drop valid before ready without effect.
//  Fields are sampled only in the accept cycle.
//  Reset (any state, incl. mid-ACCESS): state=IDLE, starve_cnt=0.
//   All resp_valid=0, readys=0 for the reset cycle, rdata regs=0, mem_w_en=0.
//   In-flight transaction dropped, no response.
// CONFIGURATION
//  ARB_PERF_CNT_EN defined: adds outputs perf_i_grants, perf_d_grants and
//   perf_conflicts (CNT_W each, saturating, reset 0).
//   - perf_*_grants: +1 per accept.
//   - perf_conflicts: +1 per IDLE cycle with both valid.
//  ARB_PERF_CNT_EN undefined: these ports and registers do not exist.
//   Arbitration and timing are identical either way.
// TESTING
//  T1 IF-only fetch: mem[0x0..0x3]=13 05 00 00, i_addr=0x0 -> i_req_ready at t0,
//     i_resp_valid at t0+2, i_rdata=0x00000513.
//  T2 Store then load: d_addr=0x100, wmask=4'b0011, wdata=0xAABBCCDD.
//     Load 0x100 -> d_rdata=0x0000CCDD (bytes 0x102/0x103 were 0).
//  T3 Contention: i and d held valid continuously -> grants d,d,d,d,i repeating
//     (STARVE_LIMIT=4). No grant to either is lost.
//  T4 Reset in ACCESS of store 0xFF to 0x200 -> rst asserted that cycle: mem[0x200]
//     unchanged, no d_resp_valid, next cycle state IDLE.
//  T5 Zero-mask store: d_we=1, wmask=0 -> d_resp_valid at t0+2, d_rdata=0,
//     memory unchanged.
//  T6 (ARB_PERF_CNT_EN) T3 for 15 grants -> perf_d_grants=12, perf_i_grants=3,
//     perf_conflicts=15.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// =====================================================================
// Module   : unified_mem_arbiter
// Purpose  : Serialises IF fetches and MEM loads/stores onto one unified
//            byte-addressed memory with registered responses and an IF
//            starvation guard. Define ARB_PERF_CNT_EN for perf counters.
// Revision : 1.0 - initial release
// =====================================================================
module unified_mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req_valid,
    output logic                  i_req_ready,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_resp_valid,
    output logic [DATA_W-1:0]     i_rdata,
    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_wmask,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_resp_valid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic [DATA_W/8-1:0]   mem_w_en,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      perf_i_grants,
    output logic [CNT_W-1:0]      perf_d_grants,
    output logic [CNT_W-1:0]      perf_conflicts
`endif
);

    localparam int         c_MASK_W     = DATA_W / 8;
    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_owner_d;
    logic                  r_we;
    logic [ADDR_W-1:0]     r_addr;
    logic [c_MASK_W-1:0]   r_mask;
    logic [DATA_W-1:0]     r_wdata;
    logic [3:0]            r_starve_cnt;
    logic [DATA_W-1:0]     r_i_rdata;
    logic [DATA_W-1:0]     r_d_rdata;
    logic                  r_i_resp;
    logic                  r_d_resp;

    logic                  w_idle;
    logic                  w_access;
    logic                  w_starved;
    logic                  w_grant_i;
    logic                  w_grant_d;

    // d has priority unless IF has lost STARVE_LIMIT times in a row
    assign w_starved = (r_starve_cnt == c_STARVE_MAX);
    assign w_grant_i = i_req_valid && (!d_req_valid || w_starved);
    assign w_grant_d = d_req_valid && !w_grant_i;

    assign w_idle      = (r_state == ST_IDLE) && !rst;
    assign i_req_ready = w_idle && w_grant_i;
    assign d_req_ready = w_idle && w_grant_d;

    // Memory port is driven only in ACCESS; reset suppresses an in-flight write
    assign w_access    = (r_state == ST_ACCESS) && !rst;
    assign mem_w_en    = w_access ? r_mask  : '0;
    assign mem_address = w_access ? r_addr  : '0;
    assign mem_wdata   = w_access ? r_wdata : '0;

    assign i_resp_valid = r_i_resp && !rst;
    assign d_resp_valid = r_d_resp && !rst;
    assign i_rdata      = r_i_rdata;
    assign d_rdata      = r_d_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner_d    <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_mask       <= '0;
            r_wdata      <= '0;
            r_starve_cnt <= 4'd0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
            r_i_resp     <= 1'b0;
            r_d_resp     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_i_resp <= 1'b0;
                    r_d_resp <= 1'b0;
                    if (i_req_ready) begin
                        r_starve_cnt <= 4'd0;
                    end else if (i_req_valid && (r_starve_cnt < c_STARVE_MAX)) begin
                        r_starve_cnt <= r_starve_cnt + 4'd1;
                    end
                    if (i_req_ready || d_req_ready) begin
                        r_owner_d <= d_req_ready;
                        r_addr    <= d_req_ready ? d_addr : i_addr;
                        r_we      <= d_req_ready && d_we;
                        r_mask    <= (d_req_ready && d_we) ? d_wmask : '0;
                        r_wdata   <= (d_req_ready && d_we) ? d_wdata : '0;
                        r_state   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (r_owner_d) begin
                        r_d_rdata <= r_we ? '0 : mem_rdata;
                        r_d_resp  <= 1'b1;
                    end else begin
                        r_i_rdata <= mem_rdata;
                        r_i_resp  <= 1'b1;
                    end
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    r_i_resp <= 1'b0;
                    r_d_resp <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_i_resp <= 1'b0;
                    r_d_resp <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [CNT_W-1:0] r_perf_i;
    logic [CNT_W-1:0] r_perf_d;
    logic [CNT_W-1:0] r_perf_conf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_i    <= '0;
            r_perf_d    <= '0;
            r_perf_conf <= '0;
        end else begin
            if (i_req_ready && (r_perf_i != '1)) begin
                r_perf_i <= r_perf_i + CNT_W'(1);
            end
            if (d_req_ready && (r_perf_d != '1)) begin
                r_perf_d <= r_perf_d + CNT_W'(1);
            end
            if ((r_state == ST_IDLE) && i_req_valid && d_req_valid && (r_perf_conf != '1)) begin
                r_perf_conf <= r_perf_conf + CNT_W'(1);
            end
        end
    end

    assign perf_i_grants  = r_perf_i;
    assign perf_d_grants  = r_perf_d;
    assign perf_conflicts = r_perf_conf;
`else
    logic w_perf_unused;
    assign w_perf_unused = (CNT_W > 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// Testbench for unified_mem_arbiter: directed scenarios plus random serial
// traffic checked against a byte-array reference memory.
module tb_unified_mem_arbiter;
    localparam int ADDR_W       = 16;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 4;
    localparam int CNT_W        = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_valid, i_req_ready, i_resp_valid;
    logic [15:0] i_addr;
    logic [31:0] i_rdata;
    logic        d_req_valid, d_req_ready, d_we, d_resp_valid;
    logic [15:0] d_addr;
    logic [3:0]  d_wmask;
    logic [31:0] d_wdata, d_rdata;
    logic [3:0]  mem_w_en;
    logic [15:0] mem_address;
    logic [31:0] mem_wdata, mem_rdata;
`ifdef ARB_PERF_CNT_EN
    logic [CNT_W-1:0] perf_i_grants, perf_d_grants, perf_conflicts;
`endif

    always #5 clk = ~clk;

    unified_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
        .i_resp_valid(i_resp_valid), .i_rdata(i_rdata),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
        .d_we(d_we), .d_wmask(d_wmask), .d_wdata(d_wdata),
        .d_resp_valid(d_resp_valid), .d_rdata(d_rdata),
        .mem_w_en(mem_w_en), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef ARB_PERF_CNT_EN
        , .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
        .perf_conflicts(perf_conflicts)
`endif
    );

    logic [7:0]  mem     [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic        mem_init;
    int unsigned salt;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] last_i, last_d;

    function automatic logic [7:0] init_byte(input logic [15:0] a, input int unsigned s);
        if (a == 16'h0) return 8'h13;
        if (a == 16'h1) return 8'h05;
        if (a < 16'h4) return 8'h00;
        if (a >= 16'h100 && a < 16'h104) return 8'h00;
        if (a >= 16'h200 && a < 16'h204) return 8'h5A;
        return 8'((32'(a) * 32'd37) ^ (32'(a) >> 5) ^ s);
    endfunction

    // Memory model: combinational little-endian read, byte-masked posedge write
    always @(posedge clk) begin
        if (mem_init) begin
            for (int a = 0; a < 65536; a++) mem[a] <= init_byte(16'(a), salt);
        end else begin
            for (int b = 0; b < 4; b++)
                if (mem_w_en[b]) mem[16'(mem_address + 16'(b))] <= mem_wdata[8*b +: 8];
        end
    end

    always_comb begin
        mem_rdata = '0;
        for (int b = 0; b < 4; b++) mem_rdata[8*b +: 8] = mem[16'(mem_address + 16'(b))];
    end

    function automatic logic [31:0] ref_word(input logic [15:0] a);
        logic [31:0] w;
        w = '0;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = ref_mem[16'(a + 16'(b))];
        return w;
    endfunction

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        logic [31:0] w;
        w = '0;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = mem[16'(a + 16'(b))];
        return w;
    endfunction

    task automatic ref_store(input logic [15:0] a, input logic [3:0] m, input logic [31:0] wd);
        for (int b = 0; b < 4; b++)
            if (m[b]) ref_mem[16'(a + 16'(b))] = wd[8*b +: 8];
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One serial transaction from a single requester, checked cycle by cycle
    task automatic xact(input bit is_i, input logic [15:0] a, input logic we,
                        input logic [3:0] m, input logic [31:0] wd);
        logic [31:0] exp;
        int          t;
        string       nm;
        nm = is_i ? "IF" : (we ? "ST" : "LD");
        @(negedge clk);
        if (is_i) begin
            i_req_valid = 1'b1; i_addr = a;
        end else begin
            d_req_valid = 1'b1; d_addr = a; d_we = we; d_wmask = m; d_wdata = wd;
        end
        #1;
        t = 0;
        while (!(is_i ? i_req_ready : d_req_ready) && t < 20) begin
            @(negedge clk); #1; t++;
        end
        check({nm, " accepted"}, 32'(is_i ? i_req_ready : d_req_ready), 32'd1);
        check({nm, " idle w_en"}, 32'(mem_w_en), 32'd0);
        exp = we ? 32'h0 : ref_word(a);
        @(negedge clk);
        if (is_i) begin
            i_req_valid = 1'b0; i_addr = 16'($urandom);
        end else begin
            d_req_valid = 1'b0; d_addr = 16'($urandom); d_we = 1'($urandom);
            d_wmask = 4'($urandom); d_wdata = $urandom;
        end
        #1;
        check({nm, " access addr"}, 32'(mem_address), 32'(a));
        check({nm, " access w_en"}, 32'(mem_w_en), 32'(we ? m : 4'h0));
        if (we) check({nm, " access wdata"}, mem_wdata, wd);
        check({nm, " access no resp"}, 32'({i_resp_valid, d_resp_valid}), 32'd0);
        if (we) ref_store(a, m, wd);
        @(negedge clk); #1;
        check({nm, " resp pulse"}, 32'({i_resp_valid, d_resp_valid}), is_i ? 32'd2 : 32'd1);
        check({nm, " rdata"}, is_i ? i_rdata : d_rdata, exp);
        check({nm, " other rdata held"}, is_i ? d_rdata : i_rdata, is_i ? last_d : last_i);
        check({nm, " resp mem idle"}, 32'({mem_w_en, mem_address}), 32'd0);
        check({nm, " mem word"}, mem_word(a), ref_word(a));
        if (is_i) last_i = exp; else last_d = exp;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; i_req_valid = 1'b0; d_req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        last_i = '0; last_d = '0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, ni, nd, t, spur;
        logic [15:0] ra;
        int kind;
        salt = $urandom;
        rst = 1'b1; mem_init = 1'b1;
        i_req_valid = 1'b0; i_addr = '0;
        d_req_valid = 1'b0; d_addr = '0; d_we = 1'b0; d_wmask = '0; d_wdata = '0;
        last_i = '0; last_d = '0;
        for (int a = 0; a < 65536; a++) ref_mem[a] = init_byte(16'(a), salt);

        // Reset state, with both requesters valid during reset
        @(negedge clk);
        mem_init = 1'b0; i_req_valid = 1'b1; d_req_valid = 1'b1;
        #1;
        check("reset readys", 32'({i_req_ready, d_req_ready}), 32'd0);
        check("reset resp", 32'({i_resp_valid, d_resp_valid}), 32'd0);
        check("reset i_rdata", i_rdata, 32'd0);
        check("reset d_rdata", d_rdata, 32'd0);
        check("reset mem port", 32'({mem_w_en, mem_address}), 32'd0);
        @(negedge clk);
        rst = 1'b0; i_req_valid = 1'b0; d_req_valid = 1'b0;

        // T1 fetch
        xact(1'b1, 16'h0000, 1'b0, 4'h0, 32'h0);
        check("T1 i_rdata", i_rdata, 32'h0000_0513);

        // T2 partial store then load
        xact(1'b0, 16'h0100, 1'b1, 4'b0011, 32'hAABB_CCDD);
        xact(1'b0, 16'h0100, 1'b0, 4'h0, 32'h0);
        check("T2 d_rdata", d_rdata, 32'h0000_CCDD);

        // IF raises valid while busy and drops it before ready: no effect
        fork
            xact(1'b0, 16'h0004, 1'b0, 4'h0, 32'h0);
            begin
                @(negedge clk);
                @(negedge clk);
                i_req_valid = 1'b1; i_addr = 16'h0000;
                #1;
                check("drop i ready busy", 32'(i_req_ready), 32'd0);
                @(negedge clk);
                i_req_valid = 1'b0;
            end
        join
        spur = 0;
        repeat (4) begin
            @(negedge clk); #1;
            if (i_resp_valid) spur++;
        end
        check("drop i no resp", 32'(spur), 32'd0);

        // T5 zero-mask store
        xact(1'b0, 16'h0100, 1'b0, 4'h0, 32'h0);
        xact(1'b0, 16'h0300, 1'b1, 4'h0, $urandom);
        check("T5 d_rdata", d_rdata, 32'd0);

        // T4 reset during ACCESS of a store
        @(negedge clk);
        d_req_valid = 1'b1; d_addr = 16'h0200; d_we = 1'b1; d_wmask = 4'b0001; d_wdata = 32'hFF;
        #1;
        check("T4 accept", 32'(d_req_ready), 32'd1);
        @(negedge clk);
        d_req_valid = 1'b0; rst = 1'b1;
        #1;
        check("T4 w_en in reset", 32'(mem_w_en), 32'd0);
        check("T4 readys in reset", 32'({i_req_ready, d_req_ready}), 32'd0);
        @(negedge clk);
        rst = 1'b0; last_i = '0; last_d = '0;
        d_req_valid = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
        #1;
        check("T4 mem unchanged", mem_word(16'h0200), ref_word(16'h0200));
        check("T4 no resp", 32'(d_resp_valid), 32'd0);
        check("T4 rdata cleared", i_rdata | d_rdata, 32'd0);
        check("T4 idle after reset", 32'(d_req_ready), 32'd1);
        @(negedge clk);
        d_req_valid = 1'b0;
        #1;
        check("T4 access no resp", 32'(d_resp_valid), 32'd0);
        @(negedge clk); #1;
        check("T4 load resp", 32'(d_resp_valid), 32'd1);
        check("T4 load data", d_rdata, ref_word(16'h0200));

        // T3 contention: both held valid, IF wins every (STARVE_LIMIT+1)th grant
        do_reset();
        @(negedge clk);
        i_req_valid = 1'b1; i_addr = 16'h0000;
        d_req_valid = 1'b1; d_addr = 16'h0100; d_we = 1'b0;
        g = 0; ni = 0; nd = 0; t = 0;
        while (g < 15 && t < 100) begin
            #1;
            if (i_req_ready || d_req_ready) begin
                check($sformatf("T3 grant %0d", g), 32'({i_req_ready, d_req_ready}),
                      ((g % (STARVE_LIMIT + 1)) == STARVE_LIMIT) ? 32'd2 : 32'd1);
                g++;
            end
            if (i_resp_valid) begin
                ni++;
                check("T3 i_rdata", i_rdata, ref_word(16'h0000));
            end
            if (d_resp_valid) begin
                nd++;
                check("T3 d_rdata", d_rdata, ref_word(16'h0100));
            end
            @(negedge clk);
            t++;
        end
        check("T3 grants done", 32'(g), 32'd15);
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        repeat (3) begin
            #1;
            if (i_resp_valid) ni++;
            if (d_resp_valid) nd++;
            @(negedge clk);
        end
        check("T3 i responses", 32'(ni), 32'd3);
        check("T3 d responses", 32'(nd), 32'd12);
`ifdef ARB_PERF_CNT_EN
        check("T6 perf_d_grants", 32'(perf_d_grants), 32'd12);
        check("T6 perf_i_grants", 32'(perf_i_grants), 32'd3);
        check("T6 perf_conflicts", 32'(perf_conflicts), 32'd15);
`endif
        last_i = ref_word(16'h0000);
        last_d = ref_word(16'h0100);

        // Random serial traffic, including wrapping addresses
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 2));
            ra = 16'($urandom);
            if ($urandom_range(0, 5) == 0) ra = 16'hFFFC + 16'($urandom_range(1, 3));
            case (kind)
                0: xact(1'b1, ra, 1'b0, 4'h0, 32'h0);
                1: xact(1'b0, ra, 1'b0, 4'h0, 32'h0);
                default: xact(1'b0, ra, 1'b1, 4'($urandom), $urandom);
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
